// File: rtl/blink_code.sv
// blink_code: shows a status value on an LED as a repeating blink code.
// A status value N is shown as N short flashes, followed by a dark gap, and
// then the sequence repeats. Value 0 is shown as one long flash. All timing is
// counted in slots, and one slot is one clk cycle on which tick is high.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous reset, active low
//   tick   - slot strobe from the divider terminal count, one clk wide
//   enable - start or continue blinking
//   code   - status value to display, CW bits
//   led    - LED drive, registered, 1 = on
//   busy   - registered, high while a sequence is in progress
//   done   - registered, one-clk pulse at the end of each sequence's gap
module blink_code #(
  parameter int unsigned CW         = 4,
  parameter int unsigned SW         = 8,
  parameter int unsigned ON_SLOTS   = 1,
  parameter int unsigned OFF_SLOTS  = 1,
  parameter int unsigned GAP_SLOTS  = 4,
  parameter int unsigned LONG_SLOTS = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          enable,
  input  logic [CW-1:0] code,
  output logic          led,
  output logic          busy,
  output logic          done
);

  // Slot counters hold "slots remaining minus one", so each reload value is N-1.
  localparam logic [SW-1:0] ON_M1   = SW'(ON_SLOTS - 1);
  localparam logic [SW-1:0] OFF_M1  = SW'(OFF_SLOTS - 1);
  localparam logic [SW-1:0] GAP_M1  = SW'(GAP_SLOTS - 1);
  localparam logic [SW-1:0] LONG_M1 = SW'(LONG_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [CW-1:0] blink_q, blink_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_c;

  // Next-state logic; nothing but done moves unless tick is high.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    blink_d = blink_q;
    led_d   = led_q;
    done_d  = 1'b0;
    start_c = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (enable) start_c = 1'b1;
          else        led_d   = 1'b0;
        end
        ON: begin
          if (slot_q != '0) begin
            slot_d = slot_q - SW'(1);
          end else begin
            state_d = OFF;
            led_d   = 1'b0;
            slot_d  = OFF_M1;
          end
        end
        OFF: begin
          if (slot_q != '0) begin
            slot_d = slot_q - SW'(1);
          end else if (blink_q > CW'(1)) begin
            blink_d = blink_q - CW'(1);
            state_d = ON;
            led_d   = 1'b1;
            slot_d  = ON_M1;
          end else begin
            state_d = GAP;
            slot_d  = GAP_M1;
          end
        end
        GAP: begin
          if (slot_q != '0) begin
            slot_d = slot_q - SW'(1);
          end else begin
            done_d = 1'b1;
            // Re-entering ON directly keeps a repeating code free of an idle slot.
            if (enable) begin
              start_c = 1'b1;
            end else begin
              state_d = IDLE;
              led_d   = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Latch point: code is sampled only here, so mid-sequence changes wait.
    if (start_c) begin
      state_d = ON;
      led_d   = 1'b1;
      if (code != '0) begin
        blink_d = code;
        slot_d  = ON_M1;
      end else begin
        blink_d = CW'(1);
        slot_d  = LONG_M1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      blink_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      blink_q <= blink_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_blink_code.sv
// Bench for blink_code: two instances (default timing and a 2/3/8 slot
// variant) checked against a sequence-position model every clock.
module tb_blink_code;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          en1, en2;
  logic [CW-1:0] code1, code2;
  logic          led1, busy1, done1;
  logic          led2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blink_code #(.CW(CW), .SW(8), .ON_SLOTS(1), .OFF_SLOTS(1), .GAP_SLOTS(4), .LONG_SLOTS(6)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .enable(en1), .code(code1),
    .led(led1), .busy(busy1), .done(done1)
  );

  blink_code #(.CW(CW), .SW(8), .ON_SLOTS(2), .OFF_SLOTS(3), .GAP_SLOTS(8), .LONG_SLOTS(6)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .enable(en2), .code(code2),
    .led(led2), .busy(busy2), .done(done2)
  );

  // ---------------- reference model ----------------
  // A sequence is a list of slot positions; each position has a fixed led value.
  bit m_active [2];
  int m_pos    [2];
  int m_len    [2];
  int m_code   [2];
  bit m_led    [2];
  bit m_busy   [2];
  bit m_done   [2];

  function automatic int on_s(int i);  return (i == 0) ? 1 : 2; endfunction
  function automatic int off_s(int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int gap_s(int i); return (i == 0) ? 4 : 8; endfunction
  function automatic int long_s(int i); return 6; endfunction

  function automatic int seq_len(int i, int c);
    if (c == 0) return long_s(i) + off_s(i) + gap_s(i);
    return c * (on_s(i) + off_s(i)) + gap_s(i);
  endfunction

  function automatic bit led_at(int i, int c, int p);
    if (c == 0) return p < long_s(i);
    return (p < c * (on_s(i) + off_s(i))) && ((p % (on_s(i) + off_s(i))) < on_s(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_pos[i] = 0; m_len[i] = 0; m_code[i] = 0;
      m_led[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step(int i, bit tk, bit en, int c);
    m_done[i] = 0;
    if (tk) begin
      if (m_active[i]) m_pos[i]++;
      if (!m_active[i] || m_pos[i] == m_len[i]) begin
        m_done[i] = m_active[i];
        if (en) begin
          m_active[i] = 1; m_code[i] = c; m_pos[i] = 0; m_len[i] = seq_len(i, c);
        end else begin
          m_active[i] = 0;
        end
      end
      m_busy[i] = m_active[i];
      m_led[i]  = m_active[i] ? led_at(i, m_code[i], m_pos[i]) : 1'b0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: advance model with the inputs seen at the edge, compare #1 later.
  task automatic cycle();
    @(posedge clk);
    model_step(0, tick, en1, int'(code1));
    model_step(1, tick, en2, int'(code2));
    #1;
    chk("led1",  int'(led1),  int'(m_led[0]));
    chk("busy1", int'(busy1), int'(m_busy[0]));
    chk("done1", int'(done1), int'(m_done[0]));
    chk("led2",  int'(led2),  int'(m_led[1]));
    chk("busy2", int'(busy2), int'(m_busy[1]));
    chk("done2", int'(done2), int'(m_done[1]));
  endtask

  // Assert reset between edges and check outputs fall without a clock.
  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_led1", int'(led1), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_led2", int'(led2), 0);
    #3 reset = 1'b1;
  endtask

  typedef struct {
    bit          tk;
    bit          en;
    logic [CW-1:0] cd;
    bit          led;
    bit          busy;
    bit          done;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int flashes, ntick, first_done, period;
    bit prev, seen;

    reset = 1'b0; tick = 1'b0; en1 = 1'b0; en2 = 1'b0; code1 = '0; code2 = '0;
    model_reset();
    #12;
    chk("init_led1", int'(led1), 0);
    chk("init_busy1", int'(busy1), 0);
    chk("init_done1", int'(done1), 0);
    #5 reset = 1'b1;

    // Code 3 on default timing, code changed to 5 mid-sequence.
    vecs[0]  = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0};

    for (int v = 0; v < 15; v++) begin
      tick = vecs[v].tk; en1 = vecs[v].en; code1 = vecs[v].cd;
      cycle();
      chk($sformatf("vec%0d_led", v),  int'(led1),  int'(vecs[v].led));
      chk($sformatf("vec%0d_busy", v), int'(busy1), int'(vecs[v].busy));
      chk($sformatf("vec%0d_done", v), int'(done1), int'(vecs[v].done));
    end
    tick = 1'b0;

    // Enable dropped after the second flash of code 4.
    do_reset();
    en1 = 1'b1; code1 = 4'd4; flashes = 0; prev = 0; seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      tick = 1'b0; cycle();
      tick = 1'b1; cycle();
      if (led1 && !prev) flashes++;
      prev = led1;
      if (t == 3) en1 = 1'b0;
      if (done1) begin
        seen = 1;
        chk("drop_busy_at_done", int'(busy1), 0);
        chk("drop_led_at_done", int'(led1), 0);
      end
    end
    chk("drop_done_seen", int'(seen), 1);
    chk("drop_flashes", flashes, 4);
    for (int t = 0; t < 5; t++) begin
      tick = 1'b0; cycle();
      tick = 1'b1; cycle();
      chk("drop_led_stays_off", int'(led1), 0);
    end
    tick = 1'b0;

    // Reset while the LED is lit, then restart on the next tick.
    en1 = 1'b1; code1 = 4'd2;
    tick = 1'b1; cycle(); tick = 1'b0;
    chk("pre_reset_led", int'(led1), 1);
    do_reset();
    cycle();
    chk("post_reset_idle_led", int'(led1), 0);
    tick = 1'b1; cycle(); tick = 1'b0;
    chk("post_reset_start_led", int'(led1), 1);
    chk("post_reset_start_busy", int'(busy1), 1);

    // Code 15 on the 2/3/8 instance with tick held high every clock.
    do_reset();
    en1 = 1'b0; en2 = 1'b1; code2 = 4'd15;
    tick = 1'b1;
    flashes = 0; prev = 0; first_done = -1; period = -1; ntick = 0;
    for (int t = 1; t <= 400 && period < 0; t++) begin
      cycle();
      if (done2) begin
        if (first_done < 0) begin
          first_done = t;
        end else begin
          period = t - first_done;
          chk("max_code_flashes", flashes, 15);
        end
        flashes = (led2 && !prev) ? 1 : 0;
      end else if (led2 && !prev) begin
        flashes++;
      end
      prev = led2;
      ntick = t;
    end
    chk("max_code_period", period, 83);
    tick = 1'b0;

    // Randomised traffic on both instances against the model.
    do_reset();
    en1 = 1'b1; en2 = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      tick = (($urandom % 3) == 0);
      if (($urandom % 50) == 0) en1 = ~en1;
      if (($urandom % 50) == 0) en2 = ~en2;
      if (($urandom % 20) == 0) code1 = CW'($urandom);
      if (($urandom % 20) == 0) code2 = CW'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_code.md
Name: blink_code

Overview:
- Consumes the single-cycle terminal-count pulse from the board clock-divider diagnostic and uses it as a slot time base.
- Flashes a status LED as a repeating blink code: N short flashes for status value N, then a gap, then repeat.
- Code 0 is shown as one long flash.
- Sits between the divider's tc output and the LED pin; lets an operator read PLL-lock, link or fault status by eye.

Parameters:
- CW, 4, width of status code input (max code 2^CW-1).
- SW, 8, width of slot counter; must hold the largest slot parameter minus 1.
- ON_SLOTS, 1, ticks LED is on per short flash (>=1).
- OFF_SLOTS, 1, ticks LED is off between flashes (>=1).
- GAP_SLOTS, 4, ticks LED is off after last flash of a sequence (>=1).
- LONG_SLOTS, 6, ticks LED is on for code 0 (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- tick  in  1  slot strobe, one clk wide, driven from the divider terminal count.
- enable  in  1  start or continue blinking.
- code  in  CW  status value to display.
- led  out  1  LED drive, registered, 1 = on.
- busy  out  1  high whenever state != IDLE, registered.
- done  out  1  one-clk pulse at end of each sequence's gap, registered.

Behaviour:
- Reset (reset low, async): state=IDLE, led=0, busy=0, done=0, slot_cnt=0, blink_cnt=0, latched code=0.
- All state changes occur only on clk edges where tick=1.
- Non-tick cycles hold all state except done, which clears to 0 every non-qualifying cycle.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - On tick & enable: latch code.
  - If code!=0: blink_cnt=code, slot_cnt=ON_SLOTS-1.
  - If code==0: blink_cnt=1, slot_cnt=LONG_SLOTS-1.
  - In both cases: state=ON, led=1.
  - On tick & !enable: stay IDLE, led=0.
- ON, on tick:
  - slot_cnt!=0: decrement.
  - slot_cnt==0: state=OFF, led=0, slot_cnt=OFF_SLOTS-1.
- OFF, on tick:
  - slot_cnt!=0: decrement.
  - slot_cnt==0 & blink_cnt>1: blink_cnt-1, state=ON, led=1, slot_cnt=ON_SLOTS-1.
  - slot_cnt==0 & blink_cnt==1: state=GAP, slot_cnt=GAP_SLOTS-1.
- GAP, on tick:
  - slot_cnt!=0: decrement.
  - slot_cnt==0: done=1 for that cycle.
  - Then, if enable: relatch code and enter ON exactly as from IDLE (no IDLE cycle).
  - Otherwise: state=IDLE.
- LED timing:
  - led rises on the clk edge of the starting tick.
  - Each short flash is on for exactly ON_SLOTS tick intervals; each inter-flash off period lasts OFF_SLOTS intervals.
  - Post-sequence dark time is OFF_SLOTS+GAP_SLOTS intervals.
- Code changes mid-sequence are ignored until the next latch point; no truncated or merged counts.
- Enable deasserted mid-sequence: the sequence runs to completion through GAP, then goes to IDLE. done still pulses.
- Enable reasserted during GAP: the sequence repeats seamlessly.
- Max code (2^CW-1) must count correctly; blink_cnt is CW bits wide and never wraps.
- Async reset mid-sequence: led drops immediately. After release, the block waits in IDLE for the next tick & enable.
- tick held high on consecutive clks: each clk counts as one slot. No edge detection is performed.
- busy is 1 from the starting tick edge through the final GAP tick edge. It deasserts on the same edge as done when returning to IDLE.

Test Plan:
- Defaults, tick every 4 clks, enable=1, code=3 -> led pattern per tick: 1,0,1,0,1,0, then 0 for 4 ticks. done pulses once at the 10th tick edge. The pattern then repeats.
- code=0 -> led high for 6 ticks, low for 1+4 ticks. done pulses every 11 ticks.
- code=3 running, change to 5 after the first flash -> current sequence shows 3 flashes. The next sequence shows 5.
- enable dropped after the second flash of code=4 -> 4 flashes complete, then the gap. done=1, busy=0 and state IDLE on that same edge. led stays 0 afterwards.
- reset pulled low while led=1 mid-sequence -> led, busy and done go 0 immediately, without waiting for a clk. After release with enable=1, the first flash starts on the next tick.
- code=15, ON_SLOTS=2, OFF_SLOTS=3, GAP_SLOTS=8 -> 15 flashes, each 2 ticks on and 3 ticks off. Sequence length is 15*5+8=83 ticks between done pulses.
